// File: rtl/inert_spi_resp_pkg.sv
// Shared definitions for the inertial sensor SPI responder: register map,
// identity value and the frame state machine encoding.
package inert_pkg;

  localparam logic [6:0] INT1_CTRL_ADDR = 7'h0D;
  localparam logic [6:0] WHO_AM_I_ADDR  = 7'h0F;
  localparam logic [6:0] CTRL1_XL_ADDR  = 7'h10;
  localparam logic [6:0] CTRL2_G_ADDR   = 7'h11;
  localparam logic [6:0] CTRL5_ADDR     = 7'h14;
  localparam logic [6:0] STATUS_ADDR    = 7'h1E;
  localparam logic [6:0] PTCH_L_ADDR    = 7'h22;
  localparam logic [6:0] PTCH_H_ADDR    = 7'h23;
  localparam logic [6:0] AZ_L_ADDR      = 7'h2C;
  localparam logic [6:0] AZ_H_ADDR      = 7'h2D;

  localparam logic [7:0] WHO_AM_I_DEFAULT = 8'h6A;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, FIN} state_t;

endpackage

// File: rtl/inert_spi_resp_if.sv
// SPI pin bundle between the master (inertial interface) and the sensor responder.
interface inert_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_spi_resp_shft.sv
// SPI front end: pin synchronizers, SCLK edge detect, 16-bit rx/tx shifters,
// bit counter and the IDLE/SHIFT/LOAD/FIN frame state machine.
module spi_resp_shft
  import inert_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ss_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic [7:0]  rd_byte,  // register contents at rd_addr, used in LOAD
  output logic        miso,
  output logic [6:0]  rd_addr,
  output logic [15:0] frame,
  output logic        commit,   // one-cycle pulse for a complete 16-bit frame
  output logic        idle
);

  logic [2:0]  ss_sync;
  logic [2:0]  sclk_sync;
  logic [1:0]  mosi_sync;
  state_t      state;
  logic [15:0] shft_rx;
  logic [15:0] shft_tx;
  logic [4:0]  bit_cnt;

  // Two sync flops per pin; the third SS_n/SCLK flop only feeds edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[1:0], ss_n};
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  logic ss_fall, ss_hi, sclk_rise, sclk_fall;
  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign ss_hi     = ss_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];

  // Frame state machine with registered MISO and shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shft_rx <= 16'h0000;
      shft_tx <= 16'h0000;
      bit_cnt <= 5'd0;
      miso    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso    <= 1'b0;
          bit_cnt <= 5'd0;
          shft_rx <= 16'h0000;
          shft_tx <= 16'h0000;
          if (ss_fall) state <= SHIFT;
        end
        SHIFT: begin
          if (ss_hi) begin
            state <= FIN;
          end else begin
            if (sclk_rise) begin
              shft_rx <= {shft_rx[14:0], mosi_sync[1]};
              if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
              // 8th bit arriving with R/W already shifted to bit 6 -> read
              if (bit_cnt == 5'd7 && shft_rx[6]) state <= LOAD;
            end
            if (sclk_fall) begin
              miso    <= shft_tx[15];
              shft_tx <= {shft_tx[14:0], 1'b0};
            end
          end
        end
        LOAD: begin
          shft_tx[15:8] <= rd_byte;
          state         <= ss_hi ? FIN : SHIFT;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_addr = shft_rx[6:0];
  assign frame   = shft_rx;
  assign commit  = (state == FIN) && (bit_cnt == 5'd16);
  assign idle    = (state == IDLE);

endmodule

// File: rtl/inert_spi_resp.sv
// Inertial sensor SPI responder: register file, sample timer and INT logic
// behind the spi_resp_shft front end.
// Optional: define INERT_STATUS_EN to add the read-only STATUS register at 0x1E
// with a data-ready mirror and a sticky overrun flag.
module inert_spi_resp
  import inert_pkg::*;
#(
  parameter int unsigned SMPL_PERIOD  = 4096,
  parameter logic [7:0]  WHO_AM_I_VAL = WHO_AM_I_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  inert_spi_resp_if.slave        spi,
  output logic                   INT,
  input  logic [15:0]            ptch_rt_src,
  input  logic [15:0]            AZ_src,
  output logic [7:0]             frm_cnt
);

  localparam logic [15:0] SmplLast = 16'(SMPL_PERIOD - 1);

  logic        miso;
  logic [6:0]  rd_addr;
  logic [15:0] frame;
  logic        commit;
  logic        idle;
  logic [7:0]  rd_byte;

  spi_resp_shft u_shft (
    .clk     (clk),
    .rst     (rst),
    .ss_n    (spi.SS_n),
    .sclk    (spi.SCLK),
    .mosi    (spi.MOSI),
    .rd_byte (rd_byte),
    .miso    (miso),
    .rd_addr (rd_addr),
    .frame   (frame),
    .commit  (commit),
    .idle    (idle)
  );

  assign spi.MISO = miso;

  logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g, ctrl5;
  logic [15:0] ptch_rt, az;
  logic [15:0] timer;
  logic        pending;
`ifdef INERT_STATUS_EN
  logic        ovr;
`endif

  logic       wr_commit, rd_commit, wrap, latch;
  logic [6:0] cmt_addr;
  logic [7:0] wdata;
  assign wr_commit = commit & ~frame[15];
  assign rd_commit = commit & frame[15];
  assign cmt_addr  = frame[14:8];
  assign wdata     = frame[7:0];
  assign wrap      = (ctrl2_g != 8'h00) && (timer == SmplLast);
  // Samples only land between frames so a multi-byte read stays coherent.
  assign latch     = (pending | wrap) & idle;

  // Read mux feeding the tx shifter during LOAD.
  always_comb begin
    rd_byte = 8'h00;
    case (rd_addr)
      INT1_CTRL_ADDR: rd_byte = int1_ctrl;
      WHO_AM_I_ADDR:  rd_byte = WHO_AM_I_VAL;
      CTRL1_XL_ADDR:  rd_byte = ctrl1_xl;
      CTRL2_G_ADDR:   rd_byte = ctrl2_g;
      CTRL5_ADDR:     rd_byte = ctrl5;
      PTCH_L_ADDR:    rd_byte = ptch_rt[7:0];
      PTCH_H_ADDR:    rd_byte = ptch_rt[15:8];
      AZ_L_ADDR:      rd_byte = az[7:0];
      AZ_H_ADDR:      rd_byte = az[15:8];
`ifdef INERT_STATUS_EN
      STATUS_ADDR:    rd_byte = {6'b000000, ovr, INT};
`endif
      default:        rd_byte = 8'h00;
    endcase
  end

  // Config register writes on committed write frames; RO/unmapped ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      int1_ctrl <= 8'h00;
      ctrl1_xl  <= 8'h00;
      ctrl2_g   <= 8'h00;
      ctrl5     <= 8'h00;
    end else if (wr_commit) begin
      case (cmt_addr)
        INT1_CTRL_ADDR: int1_ctrl <= wdata;
        CTRL1_XL_ADDR:  ctrl1_xl  <= wdata;
        CTRL2_G_ADDR:   ctrl2_g   <= wdata;
        CTRL5_ADDR:     ctrl5     <= wdata;
        default: ;
      endcase
    end
  end

  // Sample timer, pending flag and data register capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= 16'h0000;
      pending <= 1'b0;
      ptch_rt <= 16'h0000;
      az      <= 16'h0000;
    end else begin
      if (ctrl2_g == 8'h00) timer <= 16'h0000;
      else if (wrap)        timer <= 16'h0000;
      else                  timer <= timer + 16'h0001;
      if (latch)     pending <= 1'b0;
      else if (wrap) pending <= 1'b1;
      if (latch) begin
        ptch_rt <= ptch_rt_src;
        az      <= AZ_src;
      end
    end
  end

  // INT: set by a new sample, cleared by a committed pitch-low read or by
  // disabling the interrupt; setting wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      INT <= 1'b0;
    end else if (latch && int1_ctrl[1]) begin
      INT <= 1'b1;
    end else if ((rd_commit && cmt_addr == PTCH_L_ADDR) ||
                 (wr_commit && cmt_addr == INT1_CTRL_ADDR && !wdata[1])) begin
      INT <= 1'b0;
    end
  end

`ifdef INERT_STATUS_EN
  // Overrun: a sample landed while the previous one was still unread.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (latch && INT) begin
      ovr <= 1'b1;
    end else if (rd_commit && cmt_addr == STATUS_ADDR) begin
      ovr <= 1'b0;
    end
  end
`endif

  // Completed-frame counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt <= 8'h00;
    end else if (commit) begin
      frm_cnt <= frm_cnt + 8'h01;
    end
  end

endmodule
